rptr_empty_lvl: RTL and testbench

Read-side pointer and status block for the dual-clock asynchronous FIFO. It is a parametrised successor to the basic read-pointer/empty logic and runs entirely in the read clock domain. It keeps the binary read address and the Gray-coded read pointer exported to the write domain. Beyond the registered empty flag, it produces a registered fill level, a programmable almost-empty flag and a sticky underflow error. All outputs are derived from the already-synchronised write pointer `rq2_wptr`.

---
 rtl/afifo_pkg.sv | 23 ++
 rtl/gray2bin.sv | 17 +
 rtl/rptr_empty_lvl.sv | 78 +++++++
 tb/tb_rptr_empty_lvl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared definitions for the dual-clock asynchronous FIFO: pointer width and
// Gray/binary conversion helpers usable at any width up to MAXW bits.
package afifo_pkg;

    localparam int ADDRSIZE_DFLT = 4;
    localparam int PTRW          = ADDRSIZE_DFLT + 1;
    localparam int MAXW          = 32;

    // Narrower values are zero-extended; the conversions keep the upper bits zero.
    function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
        logic [MAXW-1:0] b;
        b[MAXW-1] = g[MAXW-1];
        for (int i = MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter, shared by the read and write side
// status blocks. Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int WIDTH = afifo_pkg::PTRW
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-domain pointer and status block of the async FIFO: read address, Gray
// read pointer, empty, fill level, programmable almost-empty and sticky underflow.
module rptr_empty_lvl
    import afifo_pkg::*;
#(
    parameter int ADDRSIZE = PTRW - 1,
    parameter int AE_RESET = 1
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic                ae_thresh_we,
    input  logic [ADDRSIZE:0]   ae_thresh,
    input  logic                runderflow_clr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] DEPTH   = PW'(1 << ADDRSIZE);
    localparam logic [PW-1:0] THR_RST = (AE_RESET > (1 << ADDRSIZE)) ? DEPTH : PW'(AE_RESET);

    logic          pop;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] wbin;
    logic [PW-1:0] lvlnext;
    logic [PW-1:0] thr;
    logic [PW-1:0] thrnext;

    gray2bin #(
        .WIDTH (PW)
    ) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin)
    );

    assign raddr = rbin[ADDRSIZE-1:0];

    always_comb begin
        pop       = rinc & ~rempty;
        rbinnext  = rbin + PW'(pop);
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        // Modular difference stays correct across pointer wrap; DEPTH means full.
        lvlnext   = wbin - rbinnext;
        thrnext   = thr;
        if (ae_thresh_we) begin
            thrnext = (ae_thresh > DEPTH) ? DEPTH : ae_thresh;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rlevel     <= '0;
            thr        <= THR_RST;
            runderflow <= 1'b0;
        end else begin
            rbin       <= rbinnext;
            rptr       <= rgraynext;
            rempty     <= (rgraynext == rq2_wptr);
            rlevel     <= lvlnext;
            thr        <= thrnext;
            raempty    <= (lvlnext <= thrnext);
            runderflow <= (rinc & rempty) | (runderflow & ~runderflow_clr);
        end
    end

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed bench for rptr_empty_lvl (ADDRSIZE=4): the driver queues the expected
// outputs for each edge, and a negedge monitor pops and compares them.
module tb_rptr_empty_lvl;
    import afifo_pkg::*;

    typedef struct packed {
        logic [4:0] rptr;
        logic [3:0] raddr;
        logic       rempty;
        logic       raempty;
        logic [4:0] rlevel;
        logic       runderflow;
    } exp_t;

    logic       rclk;
    logic       rrst_n;
    logic       rinc;
    logic [4:0] rq2_wptr;
    logic       ae_thresh_we;
    logic [4:0] ae_thresh;
    logic       runderflow_clr;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rlevel;
    logic       runderflow;

    exp_t expQueue[$];
    int   nChecks = 0;
    int   nFail   = 0;

    rptr_empty_lvl #(
        .ADDRSIZE (4),
        .AE_RESET (1)
    ) dut (
        .rclk           (rclk),
        .rrst_n         (rrst_n),
        .rinc           (rinc),
        .rq2_wptr       (rq2_wptr),
        .ae_thresh_we   (ae_thresh_we),
        .ae_thresh      (ae_thresh),
        .runderflow_clr (runderflow_clr),
        .raddr          (raddr),
        .rptr           (rptr),
        .rempty         (rempty),
        .raempty        (raempty),
        .rlevel         (rlevel),
        .runderflow     (runderflow)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    function automatic logic [4:0] g5(input int n);
        logic [MAXW-1:0] t;
        t = bin2gray(MAXW'(n & 31));
        return t[4:0];
    endfunction

    function automatic exp_t mk(input int p, input int a, input int e, input int ae,
                                input int l, input int u);
        exp_t r;
        r.rptr       = 5'(p);
        r.raddr      = 4'(a);
        r.rempty     = 1'(e);
        r.raempty    = 1'(ae);
        r.rlevel     = 5'(l);
        r.runderflow = 1'(u);
        return r;
    endfunction

    task automatic checkField(input string name, input int act, input int req);
        nChecks++;
        if (act != req) begin
            nFail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("rptr", 32'(rptr), 32'(e.rptr));
        checkField("raddr", 32'(raddr), 32'(e.raddr));
        checkField("rempty", 32'(rempty), 32'(e.rempty));
        checkField("raempty", 32'(raempty), 32'(e.raempty));
        checkField("rlevel", 32'(rlevel), 32'(e.rlevel));
        checkField("runderflow", 32'(runderflow), 32'(e.runderflow));
        checkField("empty_iff_level0", 32'(rempty), 32'(rlevel == 5'd0));
    endtask

    always @(negedge rclk) begin
        if (expQueue.size() > 0) begin
            checkOutput(expQueue.pop_front());
        end
    end

    task automatic applyStimulus(input int rst, input int inc, input int wptr, input int we,
                                 input int thr, input int clr, input exp_t e);
        rrst_n         = 1'(rst);
        rinc           = 1'(inc);
        rq2_wptr       = 5'(wptr);
        ae_thresh_we   = 1'(we);
        ae_thresh      = 5'(thr);
        runderflow_clr = 1'(clr);
        @(posedge rclk);
        expQueue.push_back(e);
        @(negedge rclk);
    endtask

    initial begin
        rrst_n = 1'b0; rinc = 1'b0; rq2_wptr = '0;
        ae_thresh_we = 1'b0; ae_thresh = '0; runderflow_clr = 1'b0;

        // Reset with pops and a nonzero write pointer pending
        applyStimulus(0, 1, 'h07, 0, 0, 0, mk(0, 0, 1, 1, 0, 0));
        applyStimulus(0, 1, 'h07, 0, 0, 0, mk(0, 0, 1, 1, 0, 0));

        // Fill to 3 then drain to empty
        applyStimulus(1, 0, 'h02, 0, 0, 0, mk('h00, 0, 0, 0, 3, 0));
        applyStimulus(1, 1, 'h02, 0, 0, 0, mk('h01, 1, 0, 0, 2, 0));
        applyStimulus(1, 1, 'h02, 0, 0, 0, mk('h03, 2, 0, 1, 1, 0));
        applyStimulus(1, 1, 'h02, 0, 0, 0, mk('h02, 3, 1, 1, 0, 0));

        // Underflow: set, hold, set-wins-over-clear, then clear alone
        applyStimulus(1, 1, 'h02, 0, 0, 0, mk('h02, 3, 1, 1, 0, 1));
        applyStimulus(1, 1, 'h02, 0, 0, 0, mk('h02, 3, 1, 1, 0, 1));
        applyStimulus(1, 1, 'h02, 0, 0, 1, mk('h02, 3, 1, 1, 0, 1));
        applyStimulus(1, 0, 'h02, 0, 0, 1, mk('h02, 3, 1, 1, 0, 0));
        applyStimulus(1, 0, 'h02, 0, 0, 0, mk('h02, 3, 1, 1, 0, 0));

        // Reset again, then a full FIFO at threshold 1
        applyStimulus(0, 1, 'h02, 0, 0, 0, mk(0, 0, 1, 1, 0, 0));
        applyStimulus(1, 0, 'h18, 0, 0, 0, mk(0, 0, 0, 0, 16, 0));
        for (int k = 1; k <= 11; k++) begin
            applyStimulus(1, 1, 'h18, 0, 0, 0, mk(g5(k), k % 16, 0, 0, 16 - k, 0));
        end

        // Almost-empty threshold, including a write coinciding with a pop
        applyStimulus(1, 0, 'h18, 1, 4, 0, mk('h0E, 11, 0, 0, 5, 0));
        applyStimulus(1, 1, 'h18, 0, 0, 0, mk('h0A, 12, 0, 1, 4, 0));
        applyStimulus(1, 1, 'h18, 1, 2, 0, mk('h0B, 13, 0, 0, 3, 0));
        applyStimulus(1, 0, 'h18, 1, 31, 0, mk('h0B, 13, 0, 1, 3, 0));
        applyStimulus(1, 0, 'h13, 0, 0, 0, mk('h0B, 13, 0, 1, 16, 0));
        applyStimulus(1, 0, 'h13, 1, 1, 0, mk('h0B, 13, 0, 0, 16, 0));

        // Drain to a 2-word gap, then advance both pointers through the wrap
        for (int k = 14; k <= 27; k++) begin
            applyStimulus(1, 1, 'h13, 0, 0, 0, mk(g5(k), k % 16, 0, 0, 29 - k, 0));
        end
        for (int k = 28; k <= 35; k++) begin
            applyStimulus(1, 1, g5(k + 2), 0, 0, 0, mk(g5(k), k % 16, 0, 0, 2, 0));
        end

        // Last two words popped with no new writes
        applyStimulus(1, 1, g5(5), 0, 0, 0, mk(g5(4), 4, 0, 1, 1, 0));
        applyStimulus(1, 1, g5(5), 0, 0, 0, mk(g5(5), 5, 1, 1, 0, 0));
        applyStimulus(1, 0, g5(5), 0, 0, 0, mk(g5(5), 5, 1, 1, 0, 0));

        repeat (2) @(negedge rclk);
        checkField("scoreboard_drained", expQueue.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
